// File: rtl/wbc_rr_arbiter_if.sv
// Bundle of request, grant and status signals shared by the control WISHBONE masters and the round-robin arbiter.
interface wbc_rr_arbiter_if;
  logic [2:0] cyc_i;
  logic       ack_i;
  logic [2:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic [2:0] err_o;
  logic       timeout_o;
  logic [7:0] timeout_count_o;

  modport slave (
    input  cyc_i, ack_i,
    output gnt_o, gnt_id_o, busy_o, err_o, timeout_o, timeout_count_o
  );

  modport master (
    output cyc_i, ack_i,
    input  gnt_o, gnt_id_o, busy_o, err_o, timeout_o, timeout_count_o
  );
endinterface

// File: rtl/wbc_rr_arbiter.sv
// Three-master round-robin arbiter for the control WISHBONE bus (pcic, turfc, hkmc).
// Define WBC_ARB_TIMEOUT_EN to compile in the no-ack watchdog, timeout error and blocked-master mask.
module wbc_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wbc_rr_arbiter_if.slave    bus
);

`ifdef WBC_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT} state_t;
`endif

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] r_lastOwner;
  logic [1:0] r_gntId;
  logic [2:0] w_elig;
  logic       w_anyElig;
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;
  logic [1:0] w_nextOwner;
  logic [2:0] w_ownerOH;
  logic       w_grantEntry;

`ifdef WBC_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wdog;
  logic [2:0]  r_blocked;
  logic [7:0]  r_toCount;

  assign w_elig = bus.cyc_i & ~r_blocked;
`else
  logic w_unused;

  assign w_unused = bus.ack_i | TIMEOUT_CYCLES[0];
  assign w_elig   = bus.cyc_i;
`endif

  assign w_ownerOH    = 3'b001 << r_gntId;
  assign w_anyElig    = |w_elig;
  assign w_grantEntry = (r_state == S_IDLE) && w_anyElig;

  // Round-robin search order: last+1, last+2, then last itself.
  always_comb begin
    w_cand1     = (r_lastOwner == 2'd2) ? 2'd0 : r_lastOwner + 2'd1;
    w_cand2     = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;
    w_nextOwner = r_lastOwner;
    if (w_elig[w_cand1]) begin
      w_nextOwner = w_cand1;
    end else if (w_elig[w_cand2]) begin
      w_nextOwner = w_cand2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Leaving GRANT always goes via IDLE, so a hand-over costs one bubble cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_anyElig) begin
          w_stateNext = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.cyc_i[r_gntId]) begin
          w_stateNext = S_IDLE;
`ifdef WBC_ARB_TIMEOUT_EN
        end else if (!bus.ack_i && (r_wdog == LP_TO_LAST)) begin
          w_stateNext = S_ERR;
`endif
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // The last owner resets to 2 so that master 0 wins first, while the visible id starts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lastOwner <= 2'd2;
      r_gntId     <= 2'd0;
    end else if (w_grantEntry) begin
      r_lastOwner <= w_nextOwner;
      r_gntId     <= w_nextOwner;
    end
  end

`ifdef WBC_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog <= 16'd0;
    end else if (w_grantEntry) begin
      r_wdog <= 16'd0;
    end else if (r_state == S_GRANT) begin
      r_wdog <= bus.ack_i ? 16'd0 : r_wdog + 16'd1;
    end
  end

  // A timed-out master stays blocked until its cyc is seen low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_blocked <= 3'b000;
      r_toCount <= 8'd0;
    end else begin
      r_blocked <= (r_blocked | ((r_state == S_ERR) ? w_ownerOH : 3'b000)) & bus.cyc_i;
      if ((r_state == S_ERR) && (r_toCount != 8'hFF)) begin
        r_toCount <= r_toCount + 8'd1;
      end
    end
  end
`endif

  always_comb begin
    bus.gnt_o    = (r_state != S_IDLE) ? w_ownerOH : 3'b000;
    bus.busy_o   = (r_state != S_IDLE);
    bus.gnt_id_o = r_gntId;
`ifdef WBC_ARB_TIMEOUT_EN
    bus.err_o           = (r_state == S_ERR) ? w_ownerOH : 3'b000;
    bus.timeout_o       = (r_state == S_ERR);
    bus.timeout_count_o = r_toCount;
`else
    bus.err_o           = 3'b000;
    bus.timeout_o       = 1'b0;
    bus.timeout_count_o = 8'd0;
`endif
  end

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// Self-checking bench for wbc_rr_arbiter: cycle-level reference model plus directed scenarios.
// Builds with or without WBC_ARB_TIMEOUT_EN; the watchdog scenarios only run when it is defined.
module tb_wbc_rr_arbiter;
  localparam int TIMEOUT = 4;
`ifdef WBC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   passCount;
  int   checkCount;
  bit   checkEn;

  wbc_rr_arbiter_if bus();

  wbc_rr_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: owner is -1 while nothing is granted.
  int         mOwner;
  int         mLast;
  int         mId;
  int         mWait;
  int         mCount;
  logic [2:0] mBlocked;
  bit         mErr;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic a, input logic r);
    bus.cyc_i = c;
    bus.ack_i = a;
    rst       = r;
    @(negedge clk);
  endtask

  always @(posedge clk) begin : modelProc
    int         o, l, id, w, tc, cand;
    logic [2:0] blk, elig;
    bit         e, found;
    o = mOwner; l = mLast; id = mId; w = mWait; tc = mCount; blk = mBlocked; e = mErr;
    if (rst) begin
      o = -1; l = 2; id = 0; w = 0; tc = 0; blk = 3'b000; e = 1'b0;
    end else begin
      elig = bus.cyc_i & ~blk;
      if (e) begin
        blk[o] = 1'b1;
        if (tc < 255) tc++;
        o = -1;
        e = 1'b0;
      end else if (o < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          cand = (l + k) % 3;
          if (!found && elig[cand]) begin
            found = 1'b1;
            o = cand; l = cand; id = cand; w = 0;
          end
        end
      end else if (!bus.cyc_i[o]) begin
        o = -1;
      end else if (bus.ack_i) begin
        w = 0;
      end else begin
        w++;
        if (TO_EN && w >= TIMEOUT) e = 1'b1;
      end
      blk = blk & bus.cyc_i;
    end
    mOwner <= o; mLast <= l; mId <= id; mWait <= w; mCount <= tc; mBlocked <= blk; mErr <= e;
  end

  always @(negedge clk) begin : compareProc
    logic [2:0] expGnt;
    if (checkEn) begin
      expGnt = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
      checkOutput("model_gnt", {5'd0, bus.gnt_o}, {5'd0, expGnt});
      checkOutput("model_gnt_id", {6'd0, bus.gnt_id_o}, 8'(mId));
      checkOutput("model_busy", {7'd0, bus.busy_o}, {7'd0, (mOwner >= 0)});
      checkOutput("model_err", {5'd0, bus.err_o}, mErr ? {5'd0, expGnt} : 8'd0);
      checkOutput("model_timeout", {7'd0, bus.timeout_o}, {7'd0, mErr});
      checkOutput("model_count", bus.timeout_count_o, 8'(mCount));
      checkOutput("onehot0_gnt", {7'd0, $onehot0(bus.gnt_o)}, 8'd1);
    end
  end

  initial begin
    passCount = 0;
    checkCount = 0;
    checkEn = 1'b0;
    rst = 1'b1;
    bus.cyc_i = 3'b000;
    bus.ack_i = 1'b0;
    @(negedge clk);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkEn = 1'b1;

    // Reset state.
    applyStimulus(3'b111, 1'b1, 1'b1);
    checkOutput("rst_gnt", {5'd0, bus.gnt_o}, 8'h00);
    checkOutput("rst_gnt_id", {6'd0, bus.gnt_id_o}, 8'h00);
    checkOutput("rst_busy", {7'd0, bus.busy_o}, 8'h00);
    checkOutput("rst_count", bus.timeout_count_o, 8'h00);

    // All three request; each drops after two granted cycles and re-requests.
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("rr_first_0", {5'd0, bus.gnt_o}, 8'h01);
    applyStimulus(3'b111, 1'b0, 1'b0);
    applyStimulus(3'b110, 1'b0, 1'b0);
    checkOutput("rr_bubble_0", {5'd0, bus.gnt_o}, 8'h00);
    checkOutput("rr_hold_id_0", {6'd0, bus.gnt_id_o}, 8'h00);
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("rr_second_1", {5'd0, bus.gnt_o}, 8'h02);
    checkOutput("rr_id_1", {6'd0, bus.gnt_id_o}, 8'h01);
    applyStimulus(3'b111, 1'b0, 1'b0);
    applyStimulus(3'b101, 1'b0, 1'b0);
    checkOutput("rr_bubble_1", {5'd0, bus.gnt_o}, 8'h00);
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("rr_third_2", {5'd0, bus.gnt_o}, 8'h04);
    applyStimulus(3'b111, 1'b0, 1'b0);
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput("rr_bubble_2", {5'd0, bus.gnt_o}, 8'h00);
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("rr_fourth_0", {5'd0, bus.gnt_o}, 8'h01);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("rr_release", {5'd0, bus.gnt_o}, 8'h00);

    // Single requester with ack every cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b010, 1'b1, 1'b0);
      checkOutput("ack_gnt", {5'd0, bus.gnt_o}, 8'h02);
      checkOutput("ack_err", {5'd0, bus.err_o}, 8'h00);
    end
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("ack_drop", {6'd0, bus.busy_o, 1'b0}, 8'h00);

    // Owner drops while another rises in the same cycle.
    applyStimulus(3'b010, 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("swap_bubble", {5'd0, bus.gnt_o}, 8'h00);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("swap_grant", {5'd0, bus.gnt_o}, 8'h04);
    applyStimulus(3'b000, 1'b0, 1'b0);

`ifdef WBC_ARB_TIMEOUT_EN
    // Master 2 stuck without ack.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(3'b100, 1'b0, 1'b0);
      checkOutput("wd_granted", {5'd0, bus.gnt_o}, 8'h04);
      checkOutput("wd_no_err", {5'd0, bus.err_o}, 8'h00);
    end
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("wd_err_gnt", {5'd0, bus.gnt_o}, 8'h04);
    checkOutput("wd_err", {5'd0, bus.err_o}, 8'h04);
    checkOutput("wd_timeout", {7'd0, bus.timeout_o}, 8'h01);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("wd_release", {5'd0, bus.gnt_o}, 8'h00);
    checkOutput("wd_count", bus.timeout_count_o, 8'h01);
    applyStimulus(3'b101, 1'b0, 1'b0);
    checkOutput("wd_other_granted", {5'd0, bus.gnt_o}, 8'h01);
    applyStimulus(3'b100, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("wd_blocked", {5'd0, bus.gnt_o}, 8'h00);
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b1, 1'b0);
    checkOutput("wd_unblocked", {5'd0, bus.gnt_o}, 8'h04);
    for (int i = 0; i < 6; i++) applyStimulus(3'b100, 1'b1, 1'b0);
    checkOutput("wd_ack_keeps", {5'd0, bus.gnt_o}, 8'h04);
    applyStimulus(3'b000, 1'b0, 1'b0);

    // Saturate the timeout counter.
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 6; i++) applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b0);
    end
    checkOutput("wd_saturated", bus.timeout_count_o, 8'hFF);
`else
    // Without the watchdog a stuck owner keeps the bus.
    for (int i = 0; i < 1000; i++) applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("stuck_gnt", {5'd0, bus.gnt_o}, 8'h01);
    checkOutput("stuck_err", {5'd0, bus.err_o}, 8'h00);
    checkOutput("stuck_count", bus.timeout_count_o, 8'h00);
    applyStimulus(3'b000, 1'b0, 1'b0);
`endif

    // Reset mid-grant.
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("rg_gnt", {5'd0, bus.gnt_o}, 8'h01);
    applyStimulus(3'b011, 1'b0, 1'b1);
    checkOutput("rg_dropped", {5'd0, bus.gnt_o}, 8'h00);
    checkOutput("rg_no_err", {5'd0, bus.err_o}, 8'h00);
    checkOutput("rg_count_clr", bus.timeout_count_o, 8'h00);
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput("rg_first_0", {5'd0, bus.gnt_o}, 8'h01);
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wbc_rr_arbiter.md
WBC_RR_ARBITER -- requirements
Module: wbc_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, range 2..65535: number of granted cycles without ack_i before a forced release.
REQ-002 SHALL have port clk_i, input, 1: the control WISHBONE bus clock (wbc_clk); all logic runs on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cyc_i, input, 3: cycle requests; bit0 is pcic, bit1 is turfc, bit2 is hkmc.
REQ-005 SHALL have port ack_i, input, 1: ack from the shared slave side, qualified by the current owner.
REQ-006 SHALL have port gnt_o, output, 3: one-hot grant, registered.
REQ-007 SHALL have port gnt_id_o, output, 2: binary index of the owner (0..2), used as the intercon mux select.
REQ-008 SHALL have port busy_o, output, 1: high whenever any gnt_o bit is high.
REQ-009 SHALL have port err_o, output, 3: one-cycle timeout error returned to the owner.
REQ-010 SHALL have port timeout_o, output, 1: one-cycle pulse on each forced release.
REQ-011 SHALL have port timeout_count_o, output, 8: saturating count of forced releases.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and ERR.
REQ-013 IDLE: if any eligible cyc_i bit is high, SHALL move to GRANT at the next edge with gnt_o set; the grant latency from cyc_i is exactly 1 cycle.
REQ-014 SHALL select the owner round-robin, searching last_owner+1, then last_owner+2, then last_owner (mod 3); the first eligible requester wins.
REQ-015 GRANT: SHALL hold gnt_o while cyc_i[owner] is high, regardless of activity on other requests.
REQ-016 GRANT: when cyc_i[owner] is low at an edge, SHALL return to IDLE with gnt_o=0; this gives exactly one bubble cycle before the next grant.
REQ-017 SHALL update last_owner on entry to GRANT.
REQ-018 gnt_id_o SHALL hold the last owner while gnt_o=0.
REQ-019 SHALL ignore ack_i outside GRANT.
REQ-020 SHALL keep gnt_o one-hot or zero in every cycle.
REQ-021 If cyc_i drops and a different cyc_i rises in the same cycle, SHALL still pass through IDLE for one cycle.

Reset
REQ-022 During rst_i the FSM SHALL be IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, err_o=0, timeout_o=0, timeout_count_o=0.
REQ-023 Reset SHALL set last_owner=2, so that master 0 wins first, and SHALL clear the blocked mask and the watchdog counter.
REQ-024 rst_i asserted mid-GRANT or mid-ERR SHALL drop the grant at that edge, with no err_o pulse.

Configuration
REQ-025 Macro WBC_ARB_TIMEOUT_EN SHALL compile in the watchdog.
REQ-026 With WBC_ARB_TIMEOUT_EN, the 16-bit watchdog counter SHALL:
- clear on GRANT entry and on every ack_i in GRANT;
- increment in each other GRANT cycle;
- on reaching TIMEOUT_CYCLES, move the FSM to ERR.
REQ-027 ERR SHALL last exactly 1 cycle with gnt_o still asserted. In that cycle:
- err_o[owner]=1 and timeout_o=1;
- timeout_count_o increments, saturating at 255;
- owner's blocked bit is set;
- next state is IDLE with gnt_o=0.
REQ-028 A blocked master SHALL be ineligible for grant until its cyc_i is sampled low, which clears its blocked bit.
REQ-029 Without WBC_ARB_TIMEOUT_EN:
- no counter or blocked mask SHALL exist;
- ERR SHALL be unreachable;
- err_o, timeout_o and timeout_count_o SHALL be constant 0;
- the FSM SHALL be IDLE/GRANT only.

Verification
REQ-030 After reset, cyc_i=3'b111 held, each master drops cyc after 2 cycles then re-requests -> grant order 0,1,2,0; one idle cycle between grants.
REQ-031 Only cyc_i[1] high for 10 cycles with ack_i every cycle -> gnt_o=3'b010 from the cycle after request to the cycle after cyc drops; busy_o tracks gnt_o; err_o stays 0.
REQ-032 WBC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, cyc_i[2] stuck high, no ack:
- err_o=3'b100 and timeout_o=1 on the fifth granted cycle;
- gnt_o=0 the next cycle;
- timeout_count_o=1;
- master 2 is not regranted while its cyc stays high;
- cyc_i[0] is granted.
REQ-033 Same setup, master 2 drops cyc for 1 cycle then re-requests -> master 2 is eligible again and is granted when round-robin reaches it.
REQ-034 rst_i pulsed while gnt_o=3'b001 -> gnt_o=0 the following cycle, no err_o; with cyc_i=3'b011 held, the next grant is master 0.
REQ-035 WBC_ARB_TIMEOUT_EN undefined, cyc_i[0] stuck for 1000 cycles with no ack -> gnt_o=3'b001 throughout and err_o=0.
